// File: rtl/hilo_collector.sv
// hilo_collector: captures ALU results into HI/LO and a 2-entry writeback FIFO.
module hilo_collector (
  input  logic        clk,
  input  logic        reset,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] out_32,
  input  logic [63:0] out_64,
  input  logic        sign_hilo,
  input  logic [4:0]  rd_addr,
  input  logic [1:0]  mf_sel,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [15:0] wb_count,
  output logic        err
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [36:0] e0, e1, rec;
  logic xfer, pop, push;
  always_comb begin
    res_ready = !reset && state != FULL;
    wb_valid  = !reset && state != EMPTY;
    wb_data   = wb_valid ? e0[31:0] : '0;
    wb_addr   = wb_valid ? e0[36:32] : '0;
    xfer      = res_valid && res_ready;
    pop       = wb_valid && wb_ready;
    push      = xfer && !sign_hilo && mf_sel != 2'b11 && rd_addr != 5'd0;
    rec       = {rd_addr, mf_sel == 2'b01 ? hi : mf_sel == 2'b10 ? lo : out_32};
  end
  // e0 is always the head; e1 only holds the second entry while FULL
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      hi       <= '0;
      lo       <= '0;
      wb_count <= '0;
      err      <= 1'b0;
      e0       <= '0;
      e1       <= '0;
    end else begin
      if (xfer && sign_hilo) begin
        hi <= out_64[63:32];
        lo <= out_64[31:0];
      end
      if (xfer && (sign_hilo ? mf_sel != 2'b00 : mf_sel == 2'b11)) err <= 1'b1;
      if (pop) wb_count <= wb_count + 16'd1;
      case (state)
        EMPTY: if (push) begin
          e0    <= rec;
          state <= ONE;
        end
        ONE: if (push && pop) e0 <= rec;
        else if (push) begin
          e1    <= rec;
          state <= FULL;
        end else if (pop) state <= EMPTY;
        FULL: if (pop) begin
          e0    <= e1;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_collector.sv
// tb_hilo_collector: scoreboard bench for hilo_collector.
module tb_hilo_collector;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] out_32 = '0;
  logic [63:0] out_64 = '0;
  logic        sign_hilo = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [1:0]  mf_sel = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] hi, lo;
  logic [15:0] wb_count;
  logic        err;
  logic [36:0] q[$];
  logic [31:0] mhi = '0, mlo = '0;
  logic [15:0] mcnt = '0;
  logic        merr = 1'b0;
  int          n_vec = 0, n_err = 0;

  hilo_collector dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
    .out_32(out_32), .out_64(out_64), .sign_hilo(sign_hilo), .rd_addr(rd_addr),
    .mf_sel(mf_sel), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .hi(hi), .lo(lo), .wb_count(wb_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare outputs against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    logic xfer;
    chk("res_ready", res_ready, !reset && q.size() < 2);
    chk("wb_valid", wb_valid, !reset && q.size() > 0);
    if (reset || q.size() == 0) begin
      if (reset) begin
        chk("wb_data_rst", wb_data, 0);
        chk("wb_addr_rst", wb_addr, 0);
      end
    end else begin
      chk("wb_data", wb_data, q[0][31:0]);
      chk("wb_addr", wb_addr, q[0][36:32]);
    end
    chk("hi", hi, mhi);
    chk("lo", lo, mlo);
    chk("err", err, merr);
    chk("wb_count", wb_count, mcnt);
    if (reset) begin
      q.delete();
      mhi = '0; mlo = '0; mcnt = '0; merr = 1'b0;
    end else begin
      xfer = res_valid && q.size() < 2;
      if (wb_ready && q.size() > 0) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (xfer) begin
        if (sign_hilo) begin
          mhi = out_64[63:32];
          mlo = out_64[31:0];
          if (mf_sel != 2'b00) merr = 1'b1;
        end else if (mf_sel == 2'b11) merr = 1'b1;
        else if (rd_addr != 5'd0)
          q.push_back({rd_addr, mf_sel == 2'b01 ? mhi : mf_sel == 2'b10 ? mlo : out_32});
      end
    end
  end

  task automatic step(input logic v, input logic sh, input logic [63:0] o64,
                      input logic [31:0] o32, input logic [4:0] rd, input logic [1:0] mf,
                      input logic wr);
    res_valid = v; sign_hilo = sh; out_64 = o64; out_32 = o32;
    rd_addr = rd; mf_sel = mf; wb_ready = wr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic wr);
    step(1'b0, 1'b0, 64'h0, 32'h0, 5'd0, 2'd0, wr);
  endtask

  initial begin
    reset = 1'b1;
    idle(0); idle(0);
    reset = 1'b0;
    step(1, 0, 0, 32'h2A, 5, 0, 0);
    @(negedge clk);
    chk("s1_valid", wb_valid, 1);
    chk("s1_addr", wb_addr, 5);
    chk("s1_data", wb_data, 32'h2A);
    idle(1); idle(0);
    @(negedge clk);
    chk("s1_count", wb_count, 1);
    step(1, 1, 64'h00000001_00000002, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 1, 0);
    step(1, 0, 0, 0, 4, 2, 0);
    @(negedge clk);
    chk("s2_hi", hi, 1);
    chk("s2_lo", lo, 2);
    chk("s2_full", res_ready, 0);
    chk("s2_head", {wb_addr, wb_data}, {5'd3, 32'd1});
    idle(1);
    @(negedge clk);
    chk("s2_second", {wb_addr, wb_data}, {5'd4, 32'd2});
    idle(1); idle(0);
    step(1, 0, 0, 32'hA1, 7, 0, 0);
    step(1, 0, 0, 32'hB2, 8, 0, 0);
    step(1, 0, 0, 32'hC3, 9, 0, 0);
    step(1, 0, 0, 32'hC3, 9, 0, 0);
    @(negedge clk);
    chk("s3_stall", res_ready, 0);
    chk("s3_head", wb_data, 32'hA1);
    step(1, 0, 0, 32'hC3, 9, 0, 1);
    step(1, 0, 0, 32'hC3, 9, 0, 0);
    idle(1); idle(1); idle(1); idle(0);
    step(1, 0, 0, 32'h55, 6, 3, 0);
    step(1, 1, 64'hDEADBEEF_12345678, 0, 6, 1, 0);
    idle(0); idle(0);
    @(negedge clk);
    chk("s4_err", err, 1);
    chk("s4_hi", hi, 32'hDEADBEEF);
    chk("s4_norec", wb_valid, 0);
    step(1, 0, 0, 32'h77, 0, 0, 0);
    idle(0);
    @(negedge clk);
    chk("s5_zero", wb_valid, 0);
    reset = 1'b1; idle(0); reset = 1'b0;
    for (int i = 0; i < 65536; i++) step(1, 0, 0, i, 5'(i % 31 + 1), 0, 1);
    res_valid = 1'b0;
    @(negedge clk);
    chk("s5_ffff", wb_count, 16'hFFFF);
    idle(1); idle(0);
    @(negedge clk);
    chk("s5_wrap", wb_count, 16'h0000);
    step(1, 0, 0, 0, 1, 3, 0);
    step(1, 1, 64'h00000009_0000000A, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 2, 2, 0, 0);
    reset = 1'b1;
    step(1, 0, 0, 3, 3, 0, 1);
    reset = 1'b0;
    idle(0);
    @(negedge clk);
    chk("s6_valid", wb_valid, 0);
    chk("s6_ready", res_ready, 1);
    chk("s6_hilo", {hi, lo}, 0);
    chk("s6_err", err, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, {$urandom, $urandom},
           $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0);
    idle(1); idle(1); idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
